alu_8bit: RTL and testbench

//   8-bit combinational-decode, registered-output ALU with 16 operations selected by alu_sel.

---
 rtl/alu_8bit.sv | 64 ++++++
 tb/tb_alu_8bit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// 8-bit ALU: sixteen operations decoded combinationally from alu_sel,
// with the result registered so it appears on alu_out one clock later.
module alu_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_sel,
   output logic [WIDTH-1:0] alu_out
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_ROL  = 4'h6;
   localparam logic [3:0] OP_ROR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_XNOR = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_EQ   = 4'hF;

   logic [WIDTH-1:0] result;

   always_comb begin
      // NOTE: default assignment first so no path through the case can infer a latch;
      // an X select also falls through to this value.
      result = '0;
      case (alu_sel)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_MUL:  result = a * b;
         OP_DIV:  result = (b == '0) ? '1 : a / b;
         OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
         OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
         OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
         OP_ROR:  result = {a[0], a[WIDTH-1:1]};
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_NAND: result = ~(a & b);
         OP_XNOR: result = ~(a ^ b);
         OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignment for registered state so every flop samples pre-edge values.
      if (!rst_n) alu_out <= '0;
      else        alu_out <= result;
   end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: expected results are queued when inputs are
// driven and compared one rising edge later against an independent integer model.
module tb_alu_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] alu_sel = '0;
   logic [7:0] alu_out;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   alu_8bit #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .alu_sel (alu_sel),
      .alu_out (alu_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_alu(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
      int ix = int'(x);
      int iy = int'(y);
      int r;
      case (s)
         4'h0: r = (ix + iy) % 256;
         4'h1: r = (ix - iy + 256) % 256;
         4'h2: r = (ix * iy) % 256;
         4'h3: r = (iy == 0) ? 255 : ix / iy;
         4'h4: r = (ix * 2) % 256;
         4'h5: r = ix / 2;
         4'h6: r = ((ix * 2) % 256) + (ix / 128);
         4'h7: r = (ix / 2) + ((ix % 2) * 128);
         4'h8: r = ix & iy;
         4'h9: r = ix | iy;
         4'hA: r = ix ^ iy;
         4'hB: r = 255 - (ix | iy);
         4'hC: r = 255 - (ix & iy);
         4'hD: r = 255 - (ix ^ iy);
         4'hE: r = (ix > iy) ? 1 : 0;
         default: r = (ix == iy) ? 1 : 0;
      endcase
      return r[7:0];
   endfunction

   // Drive one vector, push its expected value, then compare after the capturing edge.
   task automatic apply(input string tag, input logic [3:0] s, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] exp);
      alu_sel = s;
      a = x;
      b = y;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) check("sb_empty", alu_out, 8'hxx);
      else check(tag_q.pop_front(), alu_out, exp_q.pop_front());
   endtask

   initial begin
      @(posedge clk);
      #1;
      check("reset_hold", alu_out, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Arithmetic
      apply("add_wrap", 4'h0, 8'hFF, 8'h01, 8'h00);
      apply("sub_wrap", 4'h1, 8'h00, 8'h01, 8'hFF);
      apply("mul_low",  4'h2, 8'h10, 8'h10, 8'h00);
      apply("mul_ff",   4'h2, 8'hFF, 8'hFF, 8'h01);
      apply("div",      4'h3, 8'h64, 8'h07, 8'h0E);
      apply("div_zero", 4'h3, 8'h37, 8'h00, 8'hFF);
      apply("div_one",  4'h3, 8'h37, 8'h01, 8'h37);

      // Shift/rotate
      apply("shl", 4'h4, 8'h81, 8'h00, 8'h02);
      apply("shr", 4'h5, 8'h81, 8'h00, 8'h40);
      apply("rol", 4'h6, 8'h81, 8'h00, 8'h03);
      apply("ror", 4'h7, 8'h81, 8'h00, 8'hC0);
      apply("shl_80", 4'h4, 8'h80, 8'h00, 8'h00);
      apply("rol_80", 4'h6, 8'h80, 8'h00, 8'h01);
      apply("ror_01", 4'h7, 8'h01, 8'h00, 8'h80);

      // Logic/compare
      apply("and",  4'h8, 8'hF0, 8'h3C, 8'h30);
      apply("or",   4'h9, 8'hF0, 8'h3C, 8'hFC);
      apply("xor",  4'hA, 8'hF0, 8'h3C, 8'hCC);
      apply("nor",  4'hB, 8'hF0, 8'h3C, 8'h03);
      apply("nand", 4'hC, 8'hF0, 8'h3C, 8'hCF);
      apply("xnor", 4'hD, 8'hF0, 8'h3C, 8'h33);
      apply("gt_1", 4'hE, 8'h05, 8'h04, 8'h01);
      apply("gt_eq", 4'hE, 8'h04, 8'h04, 8'h00);
      apply("gt_lt", 4'hE, 8'h03, 8'h04, 8'h00);
      apply("eq_1", 4'hF, 8'h04, 8'h04, 8'h01);
      apply("eq_0", 4'hF, 8'h05, 8'h04, 8'h00);

      // Back-to-back sweep of every opcode with fixed operands
      for (int s = 0; s < 16; s++)
         apply($sformatf("sweep_%0h", s), 4'(s), 8'hA5, 8'h5A, ref_alu(4'(s), 8'hA5, 8'h5A));

      // Asynchronous reset mid-cycle: output clears before the next edge
      apply("pre_rst", 4'h9, 8'h5A, 8'h00, 8'h5A);
      alu_sel = 4'h0;
      a = 8'h11;
      b = 8'h22;
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async", alu_out, 8'h00);
      @(posedge clk);
      #1;
      check("rst_hold", alu_out, 8'h00);
      #2;
      rst_n = 1'b1;
      apply("post_rst", 4'h0, 8'h11, 8'h22, 8'h33);

      // Random vectors against the model
      for (int i = 0; i < 10000; i++) begin
         logic [3:0] rs;
         logic [7:0] ra;
         logic [7:0] rb;
         rs = 4'($urandom_range(0, 15));
         ra = 8'($urandom_range(0, 255));
         rb = (i % 16 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         apply($sformatf("rand_%0h", rs), rs, ra, rb, ref_alu(rs, ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
